// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
// Used by adder_pipe, adder_slice and the testbench model.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Lowest bit of chunk k, clamped to the operand width so trailing chunks may be empty.
  function automatic int chunk_lo(input int k, input int cw, input int w);
    return (k * cw < w) ? k * cw : w;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry-chain chunk: registered g_width-bit sum and carry-out, advancing on i_en.
module adder_slice
  import adder_pkg::*;
#(
  parameter int g_width = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [g_width-1:0] i_a,
  input  logic [g_width-1:0] i_b,
  input  logic               i_cin,
  output logic [g_width-1:0] o_sum,
  output logic               o_cout
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {o_cout, o_sum} <= '0;
    end else if (i_en) begin
      {o_cout, o_sum} <= {1'b0, i_a} + {1'b0, i_b} + {{g_width{1'b0}}, i_cin};
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with valid/ready on both sides; carry chain split into g_stages chunks.
// Optional macro ADDER_SAT_EN clamps the result to W bits and flags it on o_sat.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int g_data_width = 8,
  parameter int g_stages     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sub,
  input  logic [g_data_width-1:0] i_A,
  input  logic [g_data_width-1:0] i_B,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [g_data_width:0]   o_C,
  output logic                    o_sat
);

  localparam int W  = g_data_width;
  localparam int S  = g_stages;
  localparam int CW = ceil_div(W, S);

  logic         adv;
  logic [S-1:0] vld_p;
  logic [S-1:0] sub_p;
  logic [W-1:0] a_in;
  logic [W-1:0] bx_in;
  logic [W:0]   raw_c;

  assign o_valid = vld_p[S-1];
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign a_in    = i_A;
  assign bx_in   = (add_op_e'(i_sub) == OP_SUB) ? ~i_B : i_B;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p <= '0;
      sub_p <= '0;
    end else if (adv) begin
      vld_p[0] <= i_valid;
      sub_p[0] <= i_sub;
      for (int k = 1; k < S; k++) begin
        vld_p[k] <= vld_p[k-1];
        sub_p[k] <= sub_p[k-1];
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int LO = chunk_lo(k, CW, W);
    localparam int HI = chunk_lo(k + 1, CW, W);
    localparam int WK = HI - LO;
    localparam int RW = W - HI;

    logic          cin;
    logic          cy;
    logic [HI-1:0] acc;

    if (k == 0) begin : g_cin
      assign cin = i_sub;
    end else begin : g_cin
      assign cin = g_st[k-1].cy;
    end

    // Result bits already produced by earlier stages ride along beside the chain.
    if (k > 0) begin : g_low
      logic [LO-1:0] low_p;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) low_p <= '0;
        else if (adv) low_p <= g_st[k-1].acc;
      end
    end

    // Operand bits not yet consumed, shifted down so the next chunk starts at bit 0.
    if (RW > 0) begin : g_rem
      logic [RW-1:0] a_p;
      logic [RW-1:0] b_p;
      if (k == 0) begin : g_ld
        always_ff @(posedge i_clk) begin
          if (adv) begin
            a_p <= a_in[W-1:WK];
            b_p <= bx_in[W-1:WK];
          end
        end
      end else begin : g_ld
        always_ff @(posedge i_clk) begin
          if (adv) begin
            a_p <= g_st[k-1].g_rem.a_p[RW+WK-1:WK];
            b_p <= g_st[k-1].g_rem.b_p[RW+WK-1:WK];
          end
        end
      end
    end

    if (WK > 0) begin : g_add
      logic [WK-1:0] a_k;
      logic [WK-1:0] b_k;
      logic [WK-1:0] sum_k;
      if (k == 0) begin : g_src
        assign a_k = a_in[WK-1:0];
        assign b_k = bx_in[WK-1:0];
      end else begin : g_src
        assign a_k = g_st[k-1].g_rem.a_p[WK-1:0];
        assign b_k = g_st[k-1].g_rem.b_p[WK-1:0];
      end
      adder_slice #(.g_width(WK)) u_slice (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (adv),
        .i_a   (a_k),
        .i_b   (b_k),
        .i_cin (cin),
        .o_sum (sum_k),
        .o_cout(cy)
      );
      if (k == 0) begin : g_acc
        assign acc = sum_k;
      end else begin : g_acc
        assign acc = {sum_k, g_low.low_p};
      end
    end else begin : g_pass
      // Empty trailing chunk: only the carry needs one more register.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cy <= 1'b0;
        else if (adv) cy <= cin;
      end
      assign acc = g_low.low_p;
    end
  end

  // MSB is carry for add and borrow (inverted carry) for subtract.
  assign raw_c = {g_st[S-1].cy ^ sub_p[S-1], g_st[S-1].acc};

`ifdef ADDER_SAT_EN
  function automatic logic [W+1:0] sat_clamp(input logic [W:0] c, input logic sub);
    if (!c[W]) return {1'b0, c};
    return {1'b1, 1'b0, (sub ? {W{1'b0}} : {W{1'b1}})};
  endfunction

  assign {o_sat, o_C} = sat_clamp(raw_c, sub_p[S-1]);
`else
  assign o_C   = raw_c;
  assign o_sat = 1'b0;
`endif

endmodule
